// File: rtl/mem_bus_arbiter_if.sv
// Bundled I-cache, D-cache and main-memory block-port signals for mem_bus_arbiter.
// The master modport is the arbiter side; slave is the caches/memory side.
interface mem_bus_arbiter_if #(
  parameter int BLK_ADDR_W = 28,
  parameter int BLK_W      = 128
);
  logic                  i_read;
  logic [BLK_ADDR_W-1:0] i_address;
  logic [BLK_W-1:0]      i_readdata;
  logic                  i_busywait;
  logic                  d_read;
  logic                  d_write;
  logic [BLK_ADDR_W-1:0] d_address;
  logic [BLK_W-1:0]      d_writedata;
  logic [BLK_W-1:0]      d_readdata;
  logic                  d_busywait;
  logic                  m_read;
  logic                  m_write;
  logic [BLK_ADDR_W-1:0] m_address;
  logic [BLK_W-1:0]      m_writedata;
  logic [BLK_W-1:0]      m_readdata;
  logic                  m_busywait;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           m_readdata, m_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           m_read, m_write, m_address, m_writedata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           m_readdata, m_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           m_read, m_write, m_address, m_writedata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises I-cache block reads and D-cache reads/write-backs onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on ties; default is strict D priority.
module mem_bus_arbiter #(
  parameter int BLK_ADDR_W = 28,
  parameter int BLK_W      = 128
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.master   bus
);

  typedef enum logic [2:0] {IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE} state_t;

  state_t                state_q, state_d;
  logic                  rd_q, wr_q, first_q;
  logic [BLK_ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]      wdata_q, i_rdata_q, d_rdata_q;
  logic                  d_req, grant_d, grant_i, complete;

  assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Cleared to "I last" so the D-cache wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else if (grant_d) begin
      last_d_q <= 1'b1;
    end else if (grant_i) begin
      last_d_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_i = bus.i_read & (last_d_q | ~d_req);
        grant_d = d_req & ~grant_i;
`else
        grant_d = d_req;
        grant_i = bus.i_read & ~d_req;
`endif
        if (grant_d)      state_d = D_BUSY;
        else if (grant_i) state_d = I_BUSY;
      end
      // The first BUSY edge precedes the memory's registered busywait, so it never completes.
      D_BUSY: if (!first_q && !bus.m_busywait) begin
        complete = 1'b1;
        state_d  = D_DONE;
      end
      I_BUSY: if (!first_q && !bus.m_busywait) begin
        complete = 1'b1;
        state_d  = I_DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      first_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        // Read+write together is a write-back; the cache re-requests the read later.
        rd_q    <= bus.d_read & ~bus.d_write;
        wr_q    <= bus.d_write;
        addr_q  <= bus.d_address;
        wdata_q <= bus.d_writedata;
        first_q <= 1'b1;
      end else if (grant_i) begin
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
        addr_q  <= bus.i_address;
        first_q <= 1'b1;
      end else if (complete) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        if (rd_q && state_q == D_BUSY) d_rdata_q <= bus.m_readdata;
        if (rd_q && state_q == I_BUSY) i_rdata_q <= bus.m_readdata;
      end else begin
        first_q <= 1'b0;
      end
    end
  end

  assign bus.m_read      = rd_q;
  assign bus.m_write     = wr_q;
  assign bus.m_address   = addr_q;
  assign bus.m_writedata = wdata_q;
  assign bus.i_readdata  = i_rdata_q;
  assign bus.d_readdata  = d_rdata_q;
  assign bus.d_busywait  = d_req & (state_q != D_DONE);
  assign bus.i_busywait  = bus.i_read & (state_q != I_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized I/D cache agents against a block-memory model with a reference store.
module tb_mem_bus_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.BLK_ADDR_W(AW), .BLK_W(DW)) bus ();
  mem_bus_arbiter #(.BLK_ADDR_W(AW), .BLK_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [7:0] k);
    if (k == 8'h10) return 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F;
    return {4{24'h5A5A5A, k}};
  endfunction

  // Memory model: registered busywait raised on the first edge that sees a strobe,
  // held so that the strobe stays high for 'lat' cycles in total.
  bit [DW-1:0]   mem [256];
  bit            mem_wr [256];
  int            lat = 5;
  logic          mem_active = 1'b0, mem_cool = 1'b0, mem_lw = 1'b0;
  int            mem_rem = 0;
  logic [AW-1:0] mem_la;
  logic [DW-1:0] mem_lwd;
  logic [AW-1:0] log_addr [$];
  bit            rnd_phase = 1'b0;
  logic [AW-1:0] i_cur, d_cur;
  logic          d_cur_w;
  logic [DW-1:0] d_cur_wd;

  always @(posedge clk) begin
    if (reset) begin
      mem_active     <= 1'b0;
      mem_cool       <= 1'b0;
      bus.m_busywait <= 1'b0;
    end else if (mem_active) begin
      if (mem_rem <= 1) begin
        bus.m_busywait <= 1'b0;
        mem_active     <= 1'b0;
        mem_cool       <= 1'b1;
        if (mem_lw) begin
          mem[mem_la[7:0]]    <= mem_lwd;
          mem_wr[mem_la[7:0]] <= 1'b1;
        end else begin
          bus.m_readdata <= mem_wr[mem_la[7:0]] ? mem[mem_la[7:0]] : init_val(mem_la[7:0]);
        end
      end else begin
        mem_rem <= mem_rem - 1;
      end
    end else if ((bus.m_read || bus.m_write) && !mem_cool) begin
      mem_active     <= 1'b1;
      mem_rem        <= rnd_phase ? int'($urandom_range(4, 1)) : lat - 2;
      mem_la         <= bus.m_address;
      mem_lw         <= bus.m_write;
      mem_lwd        <= bus.m_writedata;
      bus.m_busywait <= 1'b1;
      log_addr.push_back(bus.m_address);
      if (rnd_phase) begin
        if (!bus.m_address[7]) begin
          chk("rnd_mem_i_addr", DW'(bus.m_address), DW'(i_cur));
          chk("rnd_mem_i_op", DW'({bus.m_read, bus.m_write}), DW'(2'b10));
        end else begin
          chk("rnd_mem_d_addr", DW'(bus.m_address), DW'(d_cur));
          chk("rnd_mem_d_op", DW'({bus.m_read, bus.m_write}), DW'(d_cur_w ? 2'b01 : 2'b10));
          if (d_cur_w) chk("rnd_mem_d_wdata", bus.m_writedata, d_cur_wd);
        end
      end
    end else if (!(bus.m_read || bus.m_write)) begin
      mem_cool <= 1'b0;
    end
  end

  // Reference store: what the memory must hold after each completed write-back.
  bit [DW-1:0] ref_mem [256];
  bit          ref_wr [256];

  task automatic ref_write(input logic [7:0] k, input logic [DW-1:0] d);
    ref_mem[k] = d;
    ref_wr[k]  = 1'b1;
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [7:0] k);
    return ref_wr[k] ? ref_mem[k] : init_val(k);
  endfunction

  typedef struct {
    bit            is_d;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    bit            chg;
    logic [DW-1:0] exp_i;
    logic [DW-1:0] exp_d;
    int            exp_cyc;
  } vec_t;

  vec_t tbl [6];

  task automatic do_reset();
    reset = 1'b1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  hi = 0, busy = 0;
    bit  done = 0;
    logic bw;
    lat = v.lat;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_address = v.addr; bus.d_writedata = v.wdata;
      bus.d_read = v.rd; bus.d_write = v.wr;
    end else begin
      bus.i_address = v.addr; bus.i_read = 1'b1;
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bw = v.is_d ? bus.d_busywait : bus.i_busywait;
      if (!bw) begin done = 1; break; end
      hi++;
      chk($sformatf("vec%0d_other_busywait", idx),
          DW'(v.is_d ? bus.i_busywait : bus.d_busywait), DW'(0));
      if (bus.m_read || bus.m_write) begin
        busy++;
        chk($sformatf("vec%0d_m_addr", idx), DW'(bus.m_address), DW'(v.addr));
        chk($sformatf("vec%0d_m_op", idx), DW'({bus.m_read, bus.m_write}), DW'(v.wr ? 2'b01 : 2'b10));
        if (v.wr) chk($sformatf("vec%0d_m_wdata", idx), bus.m_writedata, v.wdata);
        if (v.chg) bus.d_address = 28'h7;
      end
    end
    chk($sformatf("vec%0d_completed", idx), DW'(done), DW'(1));
    chk($sformatf("vec%0d_i_readdata", idx), bus.i_readdata, v.exp_i);
    chk($sformatf("vec%0d_d_readdata", idx), bus.d_readdata, v.exp_d);
    chk($sformatf("vec%0d_bus_cycles", idx), DW'(busy), DW'(v.lat));
    chk($sformatf("vec%0d_stall_cycles", idx), DW'(hi + 1), DW'(v.exp_cyc));
    @(posedge clk); #1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    if (v.wr) ref_write(v.addr[7:0], v.wdata);
  endtask

  task automatic i_agent(input int n);
    logic [AW-1:0] a;
    bit done;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      a = AW'($urandom()); a[7] = 1'b0;
      i_cur = a; bus.i_address = a; bus.i_read = 1'b1;
      done = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!bus.i_busywait) begin done = 1; break; end
      end
      chk("rnd_i_done", DW'(done), DW'(1));
      chk("rnd_i_readdata", bus.i_readdata, ref_rd(a[7:0]));
      @(posedge clk); #1 bus.i_read = 1'b0;
    end
  endtask

  task automatic d_agent(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] wd, prev;
    int op;
    bit done;
    prev = '0;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      a = AW'($urandom()); a[7] = 1'b1;
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      op = int'($urandom_range(2, 0));
      d_cur = a; d_cur_w = (op != 0); d_cur_wd = wd;
      bus.d_address = a; bus.d_writedata = wd;
      bus.d_read = (op != 1); bus.d_write = (op != 0);
      done = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!bus.d_busywait) begin done = 1; break; end
      end
      chk("rnd_d_done", DW'(done), DW'(1));
      if (op != 0) begin
        chk("rnd_d_readdata_held", bus.d_readdata, prev);
        ref_write(a[7:0], wd);
      end else begin
        prev = ref_rd(a[7:0]);
        chk("rnd_d_readdata", bus.d_readdata, prev);
      end
      @(posedge clk); #1 bus.d_read = 1'b0; bus.d_write = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base, n, ph, gap;
    bit   d_done, i_done, i_hold;
    logic [2:0] kinds;
    vec_t v;

    tbl[0] = '{0, 1, 0, 28'h0000010, '0, 5, 0, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F, '0, 7};
    tbl[1] = '{1, 0, 1, 28'h00000A3, {32{4'h1}}, 5, 0, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F, '0, 7};
    tbl[2] = '{1, 1, 0, 28'h00000A3, '0, 3, 0, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F, {32{4'h1}}, 5};
    tbl[3] = '{1, 1, 1, 28'h0000005, {32{4'h2}}, 4, 0, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F, {32{4'h1}}, 6};
    tbl[4] = '{0, 1, 0, 28'h0000005, '0, 6, 0, {32{4'h2}}, {32{4'h1}}, 8};
    tbl[5] = '{1, 1, 0, 28'h0000003, '0, 5, 1, {32{4'h2}}, 128'h5A5A5A03_5A5A5A03_5A5A5A03_5A5A5A03, 7};

    bus.i_address = '0; bus.d_address = '0; bus.d_writedata = '0;
    do_reset();
    @(negedge clk);
    chk("rst_m_read", DW'(bus.m_read), DW'(0));
    chk("rst_m_write", DW'(bus.m_write), DW'(0));
    chk("rst_m_address", DW'(bus.m_address), DW'(0));
    chk("rst_m_writedata", bus.m_writedata, DW'(0));
    chk("rst_i_readdata", bus.i_readdata, DW'(0));
    chk("rst_d_readdata", bus.d_readdata, DW'(0));
    chk("rst_i_busywait", DW'(bus.i_busywait), DW'(0));
    chk("rst_d_busywait", DW'(bus.d_busywait), DW'(0));

    for (int r = 0; r < 6; r++) run_vec(tbl[r], r);

    // Simultaneous requests: D first, then I after the DONE and IDLE cycles.
    do_reset();
    lat = 5; base = log_addr.size();
    @(posedge clk); #1;
    bus.i_address = 28'h1; bus.d_address = 28'h2; bus.i_read = 1'b1; bus.d_read = 1'b1;
    d_done = 0; i_done = 0; i_hold = 1; ph = 0; gap = 0;
    for (int c = 0; c < 100 && !i_done; c++) begin
      @(negedge clk);
      case (ph)
        0: if (bus.m_read) ph = 1;
        1: if (!bus.m_read) begin ph = 2; gap = 1; end
        2: if (bus.m_read) ph = 3; else gap++;
        default: ;
      endcase
      if (!d_done) begin
        if (!bus.i_busywait) i_hold = 0;
        if (!bus.d_busywait) begin
          d_done = 1;
          chk("sim_d_readdata", bus.d_readdata, init_val(8'h02));
        end
      end else if (!bus.i_busywait) begin
        i_done = 1;
        chk("sim_i_readdata", bus.i_readdata, init_val(8'h01));
      end
      @(posedge clk); #1;
      if (d_done) bus.d_read = 1'b0;
      if (i_done) bus.i_read = 1'b0;
    end
    chk("sim_both_done", DW'({d_done, i_done}), DW'(2'b11));
    chk("sim_i_busy_during_d", DW'(i_hold), DW'(1));
    chk("sim_gap_done_plus_idle", DW'(gap), DW'(2));
    chk("sim_txn_count", DW'(log_addr.size() - base), DW'(2));
    if (log_addr.size() >= base + 2) begin
      chk("sim_first_addr", DW'(log_addr[base]), DW'(28'h2));
      chk("sim_second_addr", DW'(log_addr[base + 1]), DW'(28'h1));
    end

    // Fairness with both caches requesting continuously.
    do_reset();
    lat = 3; base = log_addr.size();
    @(posedge clk); #1;
    bus.d_address = 28'h80; bus.i_address = 28'h0; bus.d_read = 1'b1; bus.i_read = 1'b1;
    for (int c = 0; c < 200 && log_addr.size() < base + 3; c++) @(negedge clk);
    chk("fair_three_grants", DW'(log_addr.size() >= base + 3), DW'(1));
    if (log_addr.size() >= base + 3) begin
      kinds = {log_addr[base][7], log_addr[base + 1][7], log_addr[base + 2][7]};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("fair_order_d_i_d", DW'(kinds), DW'(3'b101));
`else
      chk("fair_order_d_only", DW'(kinds), DW'(3'b111));
`endif
    end
    @(posedge clk); #1 bus.d_read = 1'b0;
    n = log_addr.size();
    for (int c = 0; c < 100 && log_addr.size() <= n; c++) @(negedge clk);
    chk("fair_next_grant_seen", DW'(log_addr.size() > n), DW'(1));
    if (log_addr.size() > n) chk("fair_i_after_d_drop", DW'(log_addr[n][7]), DW'(0));
    @(posedge clk); #1 bus.i_read = 1'b0;
    repeat (12) @(posedge clk);

    // Reset pulsed during a write-back.
    do_reset();
    v = '{1, 1, 0, 28'h00000A3, '0, 3, 0, '0, {32{4'h1}}, 5};
    run_vec(v, 6);
    lat = 6;
    @(posedge clk); #1;
    bus.d_address = 28'h0A3; bus.d_writedata = {32{4'h3}}; bus.d_write = 1'b1;
    for (int c = 0; c < 20 && !bus.m_write; c++) @(negedge clk);
    chk("rstmid_write_started", DW'(bus.m_write), DW'(1));
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("rstmid_m_write", DW'(bus.m_write), DW'(0));
    chk("rstmid_m_address", DW'(bus.m_address), DW'(0));
    chk("rstmid_d_readdata", bus.d_readdata, DW'(0));
    bus.d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    v = '{1, 1, 0, 28'h00000A3, '0, 4, 0, '0, {32{4'h1}}, 6};
    run_vec(v, 7);

    // Randomized concurrent cache traffic.
    do_reset();
    rnd_phase = 1'b1;
    fork
      i_agent(30);
      d_agent(30);
    join
    rnd_phase = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
